mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory stage behind EX. Accepts one request per handshake: ALU result or data-RAM request.
//  Drives the byte-enabled data BRAM, waits out its read latency, then aligns and extends load data.
//  Presents one registered writeback beat per accepted request, in order.
//  Performs the responder side of EX's ram_we/ram_re/addr/mask/sign_ext encoding.
// PARAMETERS
//  ADDR_W      `MEM_ADDR_WIDTH  BRAM word-address width (word = 4 bytes)
//  RD_LATENCY  1                BRAM read latency in cycles; legal values 1..3
// PORTS
//  clk             in   1       clock
//  rst             in   1       synchronous, active-high reset
//  ex_valid        in   1       EX request valid
//  ex_ready        out  1       unit can accept this cycle
//  ex_rd_we        in   1       instruction writes rd
//  ex_rd_addr      in   5       destination register
//  ex_rd_data      in   32      ALU result; used when ram_re=0
//  ex_ram_we       in   1       store request
//  ex_ram_re       in   1       load request
//  ex_ram_addr     in   ADDR_W  word address
//  ex_ram_wdata    in   32      store data, byte lane 0 (lowest address) in [31:24]
//  ex_ram_mask     in   4       lane mask, bit3 = byte addr 0 ... bit0 = byte addr 3
//  ex_ram_sext     in   1       sign-extend load result
//  bram_en         out  1       BRAM enable
//  bram_we         out  4       BRAM byte write enables (= mask on store)
//  bram_addr       out  ADDR_W  BRAM word address
//  bram_wdata      out  32      BRAM write data
//  bram_rdata      in   32      BRAM read data, valid RD_LATENCY cycles after bram_en
//  wb_valid        out  1       writeback beat valid (one cycle per request)
//  wb_rd_we        out  1       register-file write enable
//  wb_rd_addr      out  5       register-file address
//  wb_rd_data      out  32      register-file data
//  misalign_err    out  1       one-cycle pulse: memory request with mask==0
// BEHAVIOUR
//  Reset: state=IDLE, wait counter=0; ex_ready=1 in the cycle after rst deasserts.
//  Reset: all other outputs are 0.
//  rst mid-load: any in-flight read is abandoned; no wb beat is produced for it.
//  FSM IDLE:
//   - ex_ready=1; accept = ex_valid & ex_ready.
//   - BRAM outputs are combinational from the ex_* inputs only on an accept cycle; otherwise bram_en=0, bram_we=0.
//  FSM LOAD_WAIT:
//   - ex_ready=0; counter increments each cycle.
//   - At counter==RD_LATENCY-1: capture bram_rdata, go to IDLE.
//  Accept priority: ex_ram_we wins over ex_ram_re if both are set; the request is treated as a store.
//  Non-memory request accepted at T:
//   - wb_valid=1 at T+1 with wb_rd_data=ex_rd_data and wb_rd_we=ex_rd_we.
//   - Back-to-back every cycle.
//  Store accepted at T:
//   - bram_en=1, bram_we=mask, bram_addr and bram_wdata driven at T.
//   - wb_valid=1 at T+1 with wb_rd_we forced to 0.
//   - Unit stays in IDLE.
//  Load accepted at T:
//   - bram_en=1, bram_we=0 at T; state goes to LOAD_WAIT; ex_ready=0 for T+1..T+RD_LATENCY.
//   - wb_valid=1 at T+RD_LATENCY+1; ex_ready=1 again at T+RD_LATENCY+1.
//  Load extraction (r = captured word), then extend: zero-extend if sext=0, sign-extend from the MSB of the field if sext=1:
//   - 1111 -> {r[7:0],r[15:8],r[23:16],r[31:24]}
//   - 1100 -> {r[23:16],r[31:24]}
//   - 0011 -> {r[7:0],r[15:8]}
//   - 1000 -> r[31:24]
//   - 0100 -> r[23:16]
//   - 0010 -> r[15:8]
//   - 0001 -> r[7:0]
//  Misaligned request (mask==0 with ram_we or ram_re set):
//   - No BRAM access; wb_valid=1 at T+1 with wb_rd_we=0 and wb_rd_data=0.
//   - misalign_err=1 at T+1.
//  Any other mask pattern on a load: treated as misaligned.
//  wb_* outputs are registered and hold their value between beats; wb_valid is a single-cycle pulse.
//  Latched request fields (rd_addr, rd_we, mask, sext) are held from accept until wb.
//  ex_* inputs may change freely while ex_ready=0.
// TESTING
//  T1 ALU stream: 3 back-to-back non-mem requests (rd 1/2/3, data 0x11/0x22/0x33).
//     -> wb beats at T+1/T+2/T+3 in order; ex_ready stays 1; bram_en=0 throughout.
//  T2 Store: addr=5, mask=1111, wdata=0x78563412.
//     -> bram_en=1, bram_we=1111 at T; wb_valid at T+1 with wb_rd_we=0.
//  T3 LW from word 5, RD_LATENCY=2, bram_rdata=0x78563412.
//     -> ex_ready=0 at T+1..T+2; wb_valid at T+3 with wb_rd_data=0x12345678.
//  T4 Byte and half loads, r=0x80FF7F01:
//     -> LB mask 1000 = 0xFFFFFF80; LBU mask 1000 = 0x00000080.
//     -> LH mask 0011 = 0x0000017F; LH mask 1100 = 0xFFFFFF80.
//  T5 Misaligned LH (mask 0000, re=1).
//     -> bram_en=0; misalign_err pulse at T+1; wb_rd_we=0; unit stays in IDLE.
//  T6 Reset during a load: rst at T+1 with RD_LATENCY=3.
//     -> no wb_valid for the load; all outputs 0; next request is accepted normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// EX -> memory-stage request, data BRAM port and writeback beat, bundled for mem_access_unit.
// slave is the memory unit's view; master is the surrounding pipeline / BRAM view.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 10
`endif

interface mem_access_unit_if #(
    parameter int ADDR_W = `MEM_ADDR_WIDTH
);
    logic              ex_valid;
    logic              ex_ready;
    logic              ex_rd_we;
    logic [4:0]        ex_rd_addr;
    logic [31:0]       ex_rd_data;
    logic              ex_ram_we;
    logic              ex_ram_re;
    logic [ADDR_W-1:0] ex_ram_addr;
    logic [31:0]       ex_ram_wdata;
    logic [3:0]        ex_ram_mask;
    logic              ex_ram_sext;

    logic              bram_en;
    logic [3:0]        bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_wdata;
    logic [31:0]       bram_rdata;

    logic              wb_valid;
    logic              wb_rd_we;
    logic [4:0]        wb_rd_addr;
    logic [31:0]       wb_rd_data;
    logic              misalign_err;

    modport slave (
        input  ex_valid, ex_rd_we, ex_rd_addr, ex_rd_data, ex_ram_we, ex_ram_re,
               ex_ram_addr, ex_ram_wdata, ex_ram_mask, ex_ram_sext, bram_rdata,
        output ex_ready, bram_en, bram_we, bram_addr, bram_wdata,
               wb_valid, wb_rd_we, wb_rd_addr, wb_rd_data, misalign_err
    );

    modport master (
        output ex_valid, ex_rd_we, ex_rd_addr, ex_rd_data, ex_ram_we, ex_ram_re,
               ex_ram_addr, ex_ram_wdata, ex_ram_mask, ex_ram_sext, bram_rdata,
        input  ex_ready, bram_en, bram_we, bram_addr, bram_wdata,
               wb_valid, wb_rd_we, wb_rd_addr, wb_rd_data, misalign_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage: ALU passthrough, byte-enabled BRAM stores and aligned/extended loads, one wb beat each.
// Latency 1 cycle (ALU/store/misaligned) or RD_LATENCY+1 (load); ex_ready drops for the load wait.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 10
`endif

module mem_access_unit #(
    parameter int ADDR_W     = `MEM_ADDR_WIDTH,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.slave  bus
);
    typedef enum logic {
        IDLE,
        LOAD_WAIT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  cnt;

    logic        accept;
    logic        is_mem;
    logic        is_store;
    logic        is_load;
    logic        mask_legal;
    logic        misalign;
    logic        load_go;
    logic        load_done;

    logic        lat_rd_we;
    logic [4:0]  lat_rd_addr;
    logic [3:0]  lat_mask;
    logic        lat_sext;
    logic [31:0] load_val;

    // Store wins when both ram_we and ram_re are set.
    assign is_store  = bus.ex_ram_we;
    assign is_load   = bus.ex_ram_re & ~bus.ex_ram_we;
    assign is_mem    = bus.ex_ram_we | bus.ex_ram_re;
    assign misalign  = is_mem & ((bus.ex_ram_mask == 4'b0000) | (is_load & ~mask_legal));
    assign load_go   = accept & is_load & ~misalign;
    assign load_done = (state == LOAD_WAIT) && (cnt == 2'(RD_LATENCY - 1));

    always_comb begin
        mask_legal = 1'b0;
        case (bus.ex_ram_mask)
            4'b1111, 4'b1100, 4'b0011,
            4'b1000, 4'b0100, 4'b0010, 4'b0001: mask_legal = 1'b1;
            default:                            mask_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // BRAM port is only driven on the accept cycle; it is idle (all zero) otherwise.
    always_comb begin
        state_nxt      = state;
        accept         = 1'b0;
        bus.ex_ready   = 1'b0;
        bus.bram_en    = 1'b0;
        bus.bram_we    = 4'b0000;
        bus.bram_addr  = {ADDR_W{1'b0}};
        bus.bram_wdata = 32'd0;
        case (state)
            IDLE: begin
                bus.ex_ready = ~rst;
                accept       = bus.ex_valid & ~rst;
                if (accept && is_mem && !misalign) begin
                    bus.bram_en   = 1'b1;
                    bus.bram_addr = bus.ex_ram_addr;
                    if (is_store) begin
                        bus.bram_we    = bus.ex_ram_mask;
                        bus.bram_wdata = bus.ex_ram_wdata;
                    end
                end
                if (load_go) begin
                    state_nxt = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                if (load_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            cnt <= 2'd0;
        end else begin
            cnt <= cnt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_rd_we   <= 1'b0;
            lat_rd_addr <= 5'd0;
            lat_mask    <= 4'b0000;
            lat_sext    <= 1'b0;
        end else if (load_go) begin
            lat_rd_we   <= bus.ex_rd_we;
            lat_rd_addr <= bus.ex_rd_addr;
            lat_mask    <= bus.ex_ram_mask;
            lat_sext    <= bus.ex_ram_sext;
        end
    end

    // Byte lane 0 (lowest address) sits in [31:24]; the field is assembled little-endian.
    always_comb begin
        logic [15:0] half;
        logic [7:0]  byte_v;
        half     = 16'd0;
        byte_v   = 8'd0;
        load_val = 32'd0;
        case (lat_mask)
            4'b1111: load_val = {bus.bram_rdata[7:0], bus.bram_rdata[15:8],
                                 bus.bram_rdata[23:16], bus.bram_rdata[31:24]};
            4'b1100: begin
                half     = {bus.bram_rdata[23:16], bus.bram_rdata[31:24]};
                load_val = {{16{lat_sext & half[15]}}, half};
            end
            4'b0011: begin
                half     = {bus.bram_rdata[7:0], bus.bram_rdata[15:8]};
                load_val = {{16{lat_sext & half[15]}}, half};
            end
            4'b1000, 4'b0100, 4'b0010, 4'b0001: begin
                case (lat_mask)
                    4'b1000: byte_v = bus.bram_rdata[31:24];
                    4'b0100: byte_v = bus.bram_rdata[23:16];
                    4'b0010: byte_v = bus.bram_rdata[15:8];
                    default: byte_v = bus.bram_rdata[7:0];
                endcase
                load_val = {{24{lat_sext & byte_v[7]}}, byte_v};
            end
            default: load_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wb_valid     <= 1'b0;
            bus.wb_rd_we     <= 1'b0;
            bus.wb_rd_addr   <= 5'd0;
            bus.wb_rd_data   <= 32'd0;
            bus.misalign_err <= 1'b0;
        end else begin
            bus.wb_valid     <= 1'b0;
            bus.misalign_err <= 1'b0;
            if (accept && misalign) begin
                bus.wb_valid     <= 1'b1;
                bus.wb_rd_we     <= 1'b0;
                bus.wb_rd_addr   <= bus.ex_rd_addr;
                bus.wb_rd_data   <= 32'd0;
                bus.misalign_err <= 1'b1;
            end else if (accept && !is_load) begin
                bus.wb_valid   <= 1'b1;
                bus.wb_rd_we   <= bus.ex_rd_we & ~is_store;
                bus.wb_rd_addr <= bus.ex_rd_addr;
                bus.wb_rd_data <= bus.ex_rd_data;
            end else if (load_done) begin
                bus.wb_valid   <= 1'b1;
                bus.wb_rd_we   <= lat_rd_we;
                bus.wb_rd_addr <= lat_rd_addr;
                bus.wb_rd_data <= load_val;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed spec cases plus random traffic against a byte-level memory model.
module tb_mem_access_unit;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(AW)) b2 ();
    mem_access_unit_if #(.ADDR_W(AW)) b3 ();

    mem_access_unit #(.ADDR_W(AW), .RD_LATENCY(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));
    mem_access_unit #(.ADDR_W(AW), .RD_LATENCY(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));

    // BRAM models with registered read and extra output pipeline stages
    logic [31:0] mem2 [16];
    logic [31:0] pipe2 [2];
    logic [31:0] mem3 [16];
    logic [31:0] pipe3 [3];

    always @(posedge clk) begin
        if (b2.bram_en) begin
            for (int k = 0; k < 4; k++)
                if (b2.bram_we[k]) mem2[b2.bram_addr][8*k +: 8] <= b2.bram_wdata[8*k +: 8];
            pipe2[0] <= mem2[b2.bram_addr];
        end
        pipe2[1] <= pipe2[0];
    end
    assign b2.bram_rdata = pipe2[1];

    always @(posedge clk) begin
        if (b3.bram_en) begin
            for (int k = 0; k < 4; k++)
                if (b3.bram_we[k]) mem3[b3.bram_addr][8*k +: 8] <= b3.bram_wdata[8*k +: 8];
            pipe3[0] <= mem3[b3.bram_addr];
        end
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign b3.bram_rdata = pipe3[2];

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] rbytes [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory, field = contiguous selected bytes, little-endian, then extend.
    task automatic model(input logic we, input logic re, input logic [AW-1:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask, input logic sext,
                         input logic rd_we, input logic [31:0] rd_data,
                         output logic mis, output logic ld, output logic st,
                         output logic exp_we, output logic [31:0] exp_data);
        int base, first, n;
        logic [31:0] v;
        base = int'(addr) * 4;
        st   = we;
        ld   = re && !we;
        mis  = (we || re) && (mask == 4'b0000 ||
               (ld && !(mask inside {4'b1111, 4'b1100, 4'b0011, 4'b1000, 4'b0100, 4'b0010, 4'b0001})));
        exp_we   = rd_we;
        exp_data = rd_data;
        if (mis) begin
            ld = 1'b0; st = 1'b0; exp_we = 1'b0; exp_data = 32'd0;
        end else if (st) begin
            exp_we = 1'b0;
            for (int k = 0; k < 4; k++)
                if (mask[3-k]) rbytes[base+k] = wdata[31-8*k -: 8];
        end else if (ld) begin
            first = 4;
            for (int k = 3; k >= 0; k--) if (mask[3-k]) first = k;
            n = $countones(mask);
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(rbytes[base+first+i]) << (8*i));
            if (sext && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            exp_data = v;
        end
    endtask

    // Call at a negedge in the cycle the request is offered; returns at the negedge of its wb beat.
    task automatic issue2(input string tag, input logic we, input logic re, input logic [AW-1:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask, input logic sext,
                          input logic rd_we, input logic [4:0] rd_addr, input logic [31:0] rd_data);
        logic mis, ld, st, ewe;
        logic [31:0] ed;
        chk({tag, ".ready"}, 32'(b2.ex_ready), 32'd1);
        b2.ex_valid = 1'b1; b2.ex_ram_we = we; b2.ex_ram_re = re; b2.ex_ram_addr = addr;
        b2.ex_ram_wdata = wdata; b2.ex_ram_mask = mask; b2.ex_ram_sext = sext;
        b2.ex_rd_we = rd_we; b2.ex_rd_addr = rd_addr; b2.ex_rd_data = rd_data;
        model(we, re, addr, wdata, mask, sext, rd_we, rd_data, mis, ld, st, ewe, ed);
        #1;
        chk({tag, ".bram_en"}, 32'(b2.bram_en), 32'(st || ld));
        chk({tag, ".bram_we"}, 32'(b2.bram_we), st ? 32'(mask) : 32'd0);
        if (st || ld) chk({tag, ".bram_addr"}, 32'(b2.bram_addr), 32'(addr));
        if (st) chk({tag, ".bram_wdata"}, b2.bram_wdata, wdata);
        @(posedge clk); @(negedge clk);
        if (ld) begin
            for (int c = 0; c < 2; c++) begin
                b2.ex_valid = 1'b1; b2.ex_ram_we = 1'($urandom); b2.ex_ram_re = 1'($urandom);
                b2.ex_ram_addr = AW'($urandom); b2.ex_ram_mask = 4'($urandom);
                b2.ex_ram_wdata = $urandom; b2.ex_rd_data = $urandom; b2.ex_rd_addr = 5'($urandom);
                #1;
                chk({tag, ".wait_ready"}, 32'(b2.ex_ready), 32'd0);
                chk({tag, ".wait_bram_en"}, 32'(b2.bram_en), 32'd0);
                chk({tag, ".wait_wb_valid"}, 32'(b2.wb_valid), 32'd0);
                @(negedge clk);
            end
            chk({tag, ".ready_back"}, 32'(b2.ex_ready), 32'd1);
        end
        b2.ex_valid = 1'b0;
        chk({tag, ".wb_valid"}, 32'(b2.wb_valid), 32'd1);
        chk({tag, ".wb_rd_we"}, 32'(b2.wb_rd_we), 32'(ewe));
        chk({tag, ".misalign_err"}, 32'(b2.misalign_err), 32'(mis));
        if (mis) chk({tag, ".wb_rd_data"}, b2.wb_rd_data, 32'd0);
        if (!mis && !st) begin
            chk({tag, ".wb_rd_addr"}, 32'(b2.wb_rd_addr), 32'(rd_addr));
            chk({tag, ".wb_rd_data"}, b2.wb_rd_data, ed);
        end
    endtask

    task automatic idle2(input string tag);
        b2.ex_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk({tag, ".idle_wb_valid"}, 32'(b2.wb_valid), 32'd0);
        chk({tag, ".idle_misalign"}, 32'(b2.misalign_err), 32'd0);
        chk({tag, ".idle_ready"}, 32'(b2.ex_ready), 32'd1);
    endtask

    initial begin
        logic [3:0] legal [7];
        logic [31:0] data;
        logic [3:0] mask;
        int kind, seen;
        legal = '{4'b1111, 4'b1100, 4'b0011, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        for (int i = 0; i < 64; i++) rbytes[i] = 8'd0;
        rst = 1'b1;
        b2.ex_valid = 1'b0; b2.ex_ram_we = 1'b0; b2.ex_ram_re = 1'b0; b2.ex_ram_addr = '0;
        b2.ex_ram_wdata = '0; b2.ex_ram_mask = '0; b2.ex_ram_sext = 1'b0;
        b2.ex_rd_we = 1'b0; b2.ex_rd_addr = '0; b2.ex_rd_data = '0;
        b3.ex_valid = 1'b0; b3.ex_ram_we = 1'b0; b3.ex_ram_re = 1'b0; b3.ex_ram_addr = '0;
        b3.ex_ram_wdata = '0; b3.ex_ram_mask = '0; b3.ex_ram_sext = 1'b0;
        b3.ex_rd_we = 1'b0; b3.ex_rd_addr = '0; b3.ex_rd_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.ready", 32'(b2.ex_ready), 32'd0);
        chk("rst.wb_valid", 32'(b2.wb_valid), 32'd0);
        chk("rst.wb_rd_data", b2.wb_rd_data, 32'd0);
        chk("rst.wb_rd_we", 32'(b2.wb_rd_we), 32'd0);
        chk("rst.misalign", 32'(b2.misalign_err), 32'd0);
        chk("rst.bram_en", 32'(b2.bram_en), 32'd0);
        rst = 1'b0;
        #1 chk("rst.ready_after", 32'(b2.ex_ready), 32'd1);
        @(negedge clk);

        // T1: ALU stream, back to back
        issue2("t1a", 0, 0, 0, 0, 0, 0, 1, 5'd1, 32'h11);
        issue2("t1b", 0, 0, 0, 0, 0, 0, 1, 5'd2, 32'h22);
        issue2("t1c", 0, 0, 0, 0, 0, 0, 1, 5'd3, 32'h33);
        idle2("t1");

        for (int w = 0; w < 16; w++)
            issue2("fill", 1, 0, AW'(w), $urandom, 4'b1111, 0, 1, 5'(w), $urandom);

        // T2 / T3
        issue2("t2", 1, 0, 4'd5, 32'h78563412, 4'b1111, 0, 1, 5'd4, 32'h5);
        issue2("t3", 0, 1, 4'd5, 0, 4'b1111, 0, 1, 5'd7, 32'h0);
        chk("t3.const", b2.wb_rd_data, 32'h12345678);

        // T4
        issue2("t4st", 1, 0, 4'd9, 32'h80FF7F01, 4'b1111, 0, 0, 5'd0, 32'h0);
        issue2("t4lb", 0, 1, 4'd9, 0, 4'b1000, 1, 1, 5'd8, 32'h0);
        chk("t4lb.const", b2.wb_rd_data, 32'hFFFFFF80);
        issue2("t4lbu", 0, 1, 4'd9, 0, 4'b1000, 0, 1, 5'd9, 32'h0);
        chk("t4lbu.const", b2.wb_rd_data, 32'h00000080);
        issue2("t4lh_lo", 0, 1, 4'd9, 0, 4'b0011, 1, 1, 5'd10, 32'h0);
        chk("t4lh_lo.const", b2.wb_rd_data, 32'h0000017F);
        issue2("t4lh_hi", 0, 1, 4'd9, 0, 4'b1100, 1, 1, 5'd11, 32'h0);
        chk("t4lh_hi.const", b2.wb_rd_data, 32'hFFFFFF80);

        // T5: misaligned
        issue2("t5", 0, 1, 4'd3, 0, 4'b0000, 1, 1, 5'd12, 32'hDEAD);
        idle2("t5");

        for (int i = 0; i < 80; i++) begin
            kind = int'($urandom_range(0, 4));
            data = $urandom;
            mask = legal[$urandom_range(0, 6)];
            case (kind)
                0: issue2("rnd_alu", 0, 0, AW'($urandom), data, mask, 1'($urandom), 1'($urandom), 5'($urandom), $urandom);
                1: issue2("rnd_st", 1, 0, AW'($urandom), data, 4'($urandom_range(1, 15)), 0, 1'($urandom), 5'($urandom), $urandom);
                2: issue2("rnd_ld", 0, 1, AW'($urandom), data, mask, 1'($urandom), 1'($urandom), 5'($urandom), $urandom);
                3: issue2("rnd_ldany", 0, 1, AW'($urandom), data, 4'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom);
                default: issue2("rnd_both", 1, 1, AW'($urandom), data, 4'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom);
            endcase
            if ($urandom_range(0, 3) == 0) idle2("rnd");
        end
        idle2("rnd_end");

        // T6: reset during a load on the latency-3 unit
        b3.ex_valid = 1'b1; b3.ex_ram_we = 1'b1; b3.ex_ram_re = 1'b0; b3.ex_ram_addr = 4'd3;
        b3.ex_ram_wdata = 32'hAABBCCDD; b3.ex_ram_mask = 4'b1111; b3.ex_rd_we = 1'b1; b3.ex_rd_addr = 5'd9;
        @(posedge clk); @(negedge clk);
        chk("t6st.wb_valid", 32'(b3.wb_valid), 32'd1);
        chk("t6st.wb_rd_we", 32'(b3.wb_rd_we), 32'd0);
        b3.ex_ram_we = 1'b0; b3.ex_ram_re = 1'b1; b3.ex_ram_mask = 4'b0001; b3.ex_ram_sext = 1'b1;
        #1 chk("t6ld.bram_en", 32'(b3.bram_en), 32'd1);
        @(posedge clk); @(negedge clk);
        b3.ex_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6.ready", 32'(b3.ex_ready), 32'd1);
        chk("t6.wb_valid", 32'(b3.wb_valid), 32'd0);
        chk("t6.wb_rd_we", 32'(b3.wb_rd_we), 32'd0);
        chk("t6.wb_rd_addr", 32'(b3.wb_rd_addr), 32'd0);
        chk("t6.wb_rd_data", b3.wb_rd_data, 32'd0);
        chk("t6.misalign", 32'(b3.misalign_err), 32'd0);
        chk("t6.bram_en", 32'(b3.bram_en), 32'd0);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (b3.wb_valid) seen++;
        end
        chk("t6.no_wb_for_abandoned_load", 32'(seen), 32'd0);
        b3.ex_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        b3.ex_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("t6re.wait_ready", 32'(b3.ex_ready), 32'd0);
            chk("t6re.wait_wb", 32'(b3.wb_valid), 32'd0);
            @(negedge clk);
        end
        chk("t6re.wb_valid", 32'(b3.wb_valid), 32'd1);
        chk("t6re.wb_rd_data", b3.wb_rd_data, 32'hFFFFFFDD);
        chk("t6re.wb_rd_addr", 32'(b3.wb_rd_addr), 32'd9);
        chk("t6re.ready", 32'(b3.ex_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
